// File: rtl/add_rr_arbiter_if.sv
// Handshake bundle between the requesters/response consumer and add_rr_arbiter.
// The master side is the client side; the slave side is the arbiter.
interface add_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/add_rr_arbiter.sv
// Round-robin arbiter sharing one signed adder across NREQ requesters, with a
// single registered response slot. Define ADD_ARB_CNT_EN to add the op_count port.
module add_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_b,
    add_rr_arbiter_if.slave   bus
`ifdef ADD_ARB_CNT_EN
    ,
    output logic [15:0]       op_count
`endif
);
    // state    | meaning
    // ST_EMPTY | response slot free, rsp_valid=0
    // ST_FULL  | response slot holds a result, rsp_valid=1
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]              state;
    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          ptr_next;
    logic [IDW-1:0]          win;
    logic                    found;
    logic                    can_accept;
    logic                    accept;
    logic [NREQ-1:0]         ready;
    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] op_b;
    logic [WIDTH:0]          sum_next;
    logic [WIDTH:0]          sum_q;
    logic [IDW-1:0]          id_q;

    function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[rot(ptr, k)]) begin
                found = 1'b1;
                win   = rot(ptr, k);
            end
        end
    end

    // rsp_ready feeds req_ready combinationally so a drain and a new accept share a cycle.
    assign can_accept = (state == ST_EMPTY) || bus.rsp_ready;
    assign accept     = rst_b && found && can_accept;

    always_comb begin
        ready = '0;
        if (accept) ready[win] = 1'b1;
    end

    assign op_a     = bus.req_a[int'(win)*WIDTH +: WIDTH];
    assign op_b     = bus.req_b[int'(win)*WIDTH +: WIDTH];
    assign sum_next = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
    assign ptr_next = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_EMPTY;
            ptr   <= '0;
            id_q  <= '0;
            sum_q <= '0;
        end else if (accept) begin
            state <= ST_FULL;
            ptr   <= ptr_next;
            id_q  <= win;
            sum_q <= sum_next;
        end else if ((state == ST_FULL) && bus.rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

`ifdef ADD_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)      op_count <= '0;
        else if (accept) op_count <= op_count + 16'd1;
    end
`endif

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == ST_FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
endmodule

// File: tb/tb_add_rr_arbiter.sv
// Directed and randomized checks of add_rr_arbiter against a rotation-order
// reference model of the grant and response slot.
module tb_add_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int SW   = W + 1;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    add_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();
`ifdef ADD_ARB_CNT_EN
    logic [15:0] op_count;
`endif

    add_rr_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
`ifdef ADD_ARB_CNT_EN
        ,
        .op_count (op_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [NREQ-1:0] v;
    int              a [NREQ];
    int              b [NREQ];
    logic            rr;

    bit             m_full;
    int             m_id;
    int             m_ptr;
    int             m_cnt;
    logic [SW-1:0]  m_sum;
    int             last_w;
    int             seq [6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rnd_op();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic drive();
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = W'(a[i]);
            bus.req_b[i*W +: W] = W'(b[i]);
        end
        bus.rsp_ready = rr;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        m_cnt  = 0;
        last_w = -1;
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase one cycle later.
    task automatic cycle();
        int       w;
        bit       can;
        logic [31:0] exp_ready;
        drive();
        #4;
        can = !m_full || rr;
        w   = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        exp_ready = (w >= 0 && can) ? (32'd1 << w) : 32'd0;
        chk("req_ready", 32'(bus.req_ready), exp_ready);
        last_w = (w >= 0 && can) ? w : -1;
        @(posedge clk);
        #1;
        if (last_w >= 0) begin
            m_full = 1'b1;
            m_id   = last_w;
            m_sum  = SW'(a[last_w] + b[last_w]);
            m_ptr  = (last_w + 1) % NREQ;
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
        if (m_full) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            chk("rsp_sum", 32'(bus.rsp_sum), 32'(m_sum));
        end
`ifdef ADD_ARB_CNT_EN
        chk("op_count", 32'(op_count), 32'(m_cnt));
`endif
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        drive();
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_sum", 32'(bus.rsp_sum), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
`ifdef ADD_ARB_CNT_EN
        chk("rst_count", 32'(op_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a[i] = 0;
            b[i] = 0;
        end
        v  = '1;
        rr = 1'b1;
        model_reset();
        do_reset();

        // single requester, sign-extension corners
        v = 4'b0001;
        a[0] = -1;   b[0] = 1;    cycle();
        chk("t1_id", 32'(bus.rsp_id), 32'd0);
        chk("t1_zero", 32'(bus.rsp_sum), 32'h000);
        a[0] = -128; b[0] = -128; cycle();
        chk("t1_neg", 32'(bus.rsp_sum), 32'h100);
        a[0] = 127;  b[0] = 127;  cycle();
        chk("t1_pos", 32'(bus.rsp_sum), 32'h0FE);
        v = '0; cycle();

        // all requesters valid: strict rotation, one result per cycle
        v = '1;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a[i] = rnd_op();
            b[i] = rnd_op();
        end
        for (int n = 0; n < 6; n++) begin
            cycle();
            chk("rot_id", 32'(bus.rsp_id), 32'(seq[n]));
            if (last_w >= 0) begin
                a[last_w] = rnd_op();
                b[last_w] = rnd_op();
            end
        end
        v = '0; cycle();

        // requesters 1 and 3 with ptr at 2
        do_reset();
        v = 4'b0010; a[1] = 1; b[1] = 1; cycle();
        v = 4'b1010;
        a[1] = -47; b[1] = 29;
        a[3] = 115; b[3] = -34;
        cycle();
        chk("p2_id3", 32'(bus.rsp_id), 32'd3);
        chk("p2_sum3", 32'(bus.rsp_sum), 32'h051);
        v = 4'b0010; cycle();
        chk("p2_id1", 32'(bus.rsp_id), 32'd1);
        chk("p2_sum1", 32'(bus.rsp_sum), 32'h1EE);
        v = '0; cycle();

        // backpressure: stalled slot holds, then drain + accept together
        v = 4'b0100; a[2] = 10; b[2] = 20; rr = 1'b1; cycle();
        v = 4'b0001; a[0] = 5; b[0] = -9; rr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("bp_id", 32'(bus.rsp_id), 32'd2);
            chk("bp_sum", 32'(bus.rsp_sum), 32'h01E);
        end
        rr = 1'b1; cycle();
        chk("bp_reload_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_reload_id", 32'(bus.rsp_id), 32'd0);
        chk("bp_reload_sum", 32'(bus.rsp_sum), 32'h1FC);
        v = '0; cycle();

        // reset one cycle after an accept discards the result
        v = 4'b0010; a[1] = 3; b[1] = 4; rr = 1'b0; cycle();
        rst_b = 1'b0;
        v = 4'b0101; a[0] = 7; b[0] = 8; a[2] = 1; b[2] = 2;
        drive();
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.rsp_sum), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", 32'(bus.rsp_valid), 32'd0);
        rst_b = 1'b1;
        model_reset();
        rr = 1'b1;
        cycle();
        chk("post_rst_id", 32'(bus.rsp_id), 32'd0);
        chk("post_rst_sum", 32'(bus.rsp_sum), 32'h00F);
        v[0] = 1'b0; cycle();
        chk("post_rst_id2", 32'(bus.rsp_id), 32'd2);
        v = '0; cycle();

        // randomized traffic with requesters honouring the hold-until-accepted rule
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    a[i] = rnd_op();
                    b[i] = rnd_op();
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_w >= 0) v[last_w] = 1'b0;
        end
        v = '0; rr = 1'b1; cycle();

`ifdef ADD_ARB_CNT_EN
        do_reset();
        v = 4'b0001; rr = 1'b1;
        for (int n = 0; n < 5; n++) begin
            a[0] = rnd_op(); b[0] = rnd_op();
            cycle();
        end
        v = '0; cycle();
        chk("cnt_five", 32'(op_count), 32'd5);
        v = 4'b0001;
        for (int n = 0; n < 65530; n++) cycle();
        chk("cnt_max", 32'(op_count), 32'h0000FFFF);
        cycle();
        chk("cnt_wrap", 32'(op_count), 32'd0);
        v = '0; cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_rr_arbiter.md
# add_rr_arbiter

- Shares one signed adder (WIDTH-bit operands, WIDTH+1-bit sum) among NREQ requesters using round-robin arbitration.
- Each requester presents an operand pair on a valid/ready handshake. The block grants one requester per cycle and computes the sign-extended sum. The result is returned, tagged with the requester id, through a single registered response slot with backpressure.
- It sits between multiple datapath clients and the shared arithmetic resource in the adder testbench/datapath family.

## Interface
Parameters:
- NREQ, default 4: number of requesters, 2..16.
- WIDTH, default 8: signed operand width.
- IDW, default $clog2(NREQ): requester id width.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NREQ*WIDTH  signed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  signed operand B; same packing as req_a.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- rsp_sum  out  WIDTH+1  signed sum.
- op_count  out  16  accepted-operation counter; present only with ADD_ARB_CNT_EN.

## Operation
- Two-state slot FSM.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant is combinational.
  - Scan indices ptr, ptr+1, … (mod NREQ); the first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
  - With no valid requests, req_ready = 0.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - rsp_sum <= sext(a_i) + sext(b_i), computed at WIDTH+1 bits; overflow is impossible.
  - rsp_id <= i.
  - state <= FULL.
  - ptr <= (i+1) mod NREQ.
- Drain without a new accept (rsp_valid & rsp_ready and no grant): state <= EMPTY.
- Simultaneous drain and accept: the slot is reloaded with the new result; rsp_valid stays 1.
- Stalled slot (FULL, rsp_ready=0): rsp_sum and rsp_id hold stable; all req_ready=0.
- ptr advances only on accept; it never moves on idle cycles.
- Requester obligation: a requester holding req_valid must keep its operands stable until accepted. The arbiter does not latch operands early.

## Timing
- Latency: accept in cycle N → rsp_valid=1 with the result in cycle N+1.
- Throughput: 1 op/cycle while rsp_ready=1.
- Reset values, applied asynchronously: state=EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, ptr=0, op_count=0. req_ready=0 while rst_b=0.
- Reset mid-operation: an in-flight result is discarded with no response. The first grant after release goes to the lowest valid index at or above 0.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. Maximum wait is NREQ-1 grants.
- ptr wrap: from NREQ-1 to 0.
- No combinational path from rsp_ready to rsp_* outputs.
- Combinational path rsp_ready → req_ready is permitted; it is needed for back-to-back throughput.

## Configuration
- ADD_ARB_CNT_EN defined:
  - op_count port exists.
  - It increments by 1 on every accept and wraps 0xFFFF→0.
  - Reset value is 0.
- ADD_ARB_CNT_EN undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Single requester 0 with a=-1, b=1: response at next cycle with rsp_sum=0, rsp_id=0. Then a=-128, b=-128 gives rsp_sum=-256. Then a=127, b=127 gives rsp_sum=254.
- All 4 requesters valid continuously, rsp_ready=1: rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Requesters 1 and 3 valid, ptr=2: grant 3 first, then 1. Requester 1 result: a=-47, b=29 gives -18. Requester 3 result: a=115, b=-34 gives 81.
- Backpressure: hold rsp_ready=0 for 3 cycles with a FULL slot.
  - rsp_sum/rsp_id stay stable and req_ready=0 throughout.
  - On rsp_ready=1, drain and a new accept happen in the same cycle.
- Reset asserted one cycle after an accept: rsp_valid=0 immediately and no response emerges. After release with requesters 2 and 0 valid, requester 0 is granted first.
- With ADD_ARB_CNT_EN: 5 accepted ops give op_count=5. Preload toward 0xFFFF and verify wrap to 0.
